// File: rtl/dm_copy_engine.sv
//------------------------------------------------------------------------------
// dm_copy_engine
//   Block-copy initiator for the data memory. On an accepted start command it
//   copies len words from src to dst, one word per RD/WR cycle pair, in
//   strictly ascending order. Address arithmetic wraps modulo 2**AW.
//   Overlapping ranges are copied forward with no direction reversal.
//
// Optional feature: define CHECKSUM_EN to add the csum output. csum is the
//   modulo-2**DW sum of the words written by the most recent command.
//
// Ports
//   clk        system clock, all state updates on posedge
//   rst        asynchronous, active-low reset
//   start      command strobe, sampled only in IDLE
//   src, dst   first source / destination address
//   len        word count, 0..2**AW (larger values are rejected via err)
//   busy       high in RD and WR states
//   done       one-cycle completion pulse
//   err        one-cycle pulse when a command is rejected
//   mem_addr   memory address
//   mem_wdata  memory write data (buffered word)
//   mem_w      memory write enable (memory commits on negedge while high)
//   mem_rdata  combinational read data for mem_addr
//   csum       checksum (CHECKSUM_EN only)
//------------------------------------------------------------------------------
module dm_copy_engine #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        src,
    input  logic [AW-1:0]        dst,
    input  logic [AW:0]          len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AW-1:0]        mem_addr,
    output logic signed [DW-1:0] mem_wdata,
    output logic                 mem_w,
    input  logic signed [DW-1:0] mem_rdata
`ifdef CHECKSUM_EN
    ,
    output logic [DW-1:0]        csum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [AW-1:0]         src_q, src_d;
    logic [AW-1:0]         dst_q, dst_d;
    logic [AW:0]           len_q, len_d;
    logic [AW:0]           idx_q, idx_d;
    logic signed [DW-1:0]  buf_q, buf_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  w_q, w_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef CHECKSUM_EN
    logic [DW-1:0]         csum_q, csum_d;
`endif

    // Every output is a register; the next-state logic computes the value
    // each output must hold during the following cycle.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        w_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len > LEN_MAX) begin
                        err_d = 1'b1;
                    end else if (len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
`ifdef CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        state_d = S_RD;
                        src_d   = src;
                        dst_d   = dst;
                        len_d   = len;
                        idx_d   = '0;
                        addr_d  = src;
                        busy_d  = 1'b1;
`ifdef CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
            end
            S_RD: begin
                state_d = S_WR;
                buf_d   = mem_rdata;
                addr_d  = dst_q + idx_q[AW-1:0];
                w_d     = 1'b1;
                busy_d  = 1'b1;
            end
            S_WR: begin
                idx_d = idx_q + IDX_ONE;
`ifdef CHECKSUM_EN
                csum_d = csum_q + buf_q;
`endif
                if (idx_d == len_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RD;
                    addr_d  = src_q + idx_d[AW-1:0];
                    busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = buf_q;
    assign mem_w     = w_q;
`ifdef CHECKSUM_EN
    assign csum      = csum_q;
`endif

endmodule

// File: tb/tb_dm_copy_engine.sv
module tb_dm_copy_engine;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        src = '0;
    logic [AW-1:0]        dst = '0;
    logic [AW:0]          len = '0;
    logic                 busy, done, err, mem_w;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] mem_wdata;
    logic signed [DW-1:0] mem_rdata;
`ifdef CHECKSUM_EN
    logic [DW-1:0]        csum;
    logic [DW-1:0]        exp_csum;
`endif

    logic signed [DW-1:0] ram     [DEPTH];
    logic signed [DW-1:0] ref_mem [DEPTH];
    logic [AW+DW-1:0]     sb [$];

    int n_vec = 0;
    int n_bad = 0;

    dm_copy_engine #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_w     (mem_w),
        .mem_rdata (mem_rdata)
`ifdef CHECKSUM_EN
        ,
        .csum      (csum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model plus scoreboard consumer: every committed write must match
    // the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (mem_w) begin
            ram[mem_addr] = mem_wdata;
            if (sb.size() == 0) begin
                chk("wr_unexpected", {23'b0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [AW+DW-1:0] e;
                e = sb.pop_front();
                chk("wr_addr", {23'b0, mem_addr}, {23'b0, e[AW+DW-1:DW]});
                chk("wr_data", {16'b0, mem_wdata}, {16'b0, e[DW-1:0]});
            end
        end
    end

    task automatic preload(input int a, input logic signed [DW-1:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic check_mem();
        int mism = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== ref_mem[i]) mism++;
        chk("mem_contents", mism, 0);
    endtask

    // Drives one command. nmod words are expected to be written (fewer than n
    // when rst_at aborts the copy). inj: cycle at which a stray start is pulsed.
    task automatic run_copy(input int s, input int d, input int n, input int nmod,
                            input int inj, input int rst_at);
        int k;
        int busy_cnt = 0;
        int err_seen = 0;
        logic got_done = 1'b0;
`ifdef CHECKSUM_EN
        exp_csum = '0;
`endif
        for (int w = 0; w < nmod; w++) begin
            int sa, da;
            sa = (s + w) % DEPTH;
            da = (d + w) % DEPTH;
            ref_mem[da] = ref_mem[sa];
            sb.push_back({AW'(da), ref_mem[da]});
`ifdef CHECKSUM_EN
            exp_csum = exp_csum + ref_mem[da];
`endif
        end
        @(negedge clk);
        src = AW'(s); dst = AW'(d); len = (AW+1)'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src = AW'($urandom); dst = AW'($urandom); len = (AW+1)'($urandom);
        k = 1;
        while (k <= 2 * n + 10) begin
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_mem_w", mem_w, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_sb_empty", sb.size(), 0);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            if (k == inj) begin
                start = 1'b1; src = 0; dst = 200; len = 3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
            busy_cnt += busy;
            err_seen |= err;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        chk("done_cycle", k, 2 * n + 1);
        chk("busy_cycles", busy_cnt, 2 * n);
        chk("err_quiet", err_seen, 0);
`ifdef CHECKSUM_EN
        chk("csum", csum, exp_csum);
`endif
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) preload(i, DW'(i * 7 + 3));

        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_w", mem_w, 0);
`ifdef CHECKSUM_EN
        chk("reset_csum", csum, 0);
`endif
        @(negedge clk);
        rst = 1'b1;

        preload(10, 1); preload(11, -2); preload(12, 300); preload(13, -32768);
        run_copy(10, 100, 4, 4, 0, 0);
        check_mem();

        preload(510, 16'sh1234); preload(511, -5); preload(0, 77); preload(1, -99);
        run_copy(510, 0, 4, 4, 0, 0);
        check_mem();

        run_copy(5, 300, 0, 0, 0, 0);
        check_mem();

        @(negedge clk);
        src = 1; dst = 2; len = 513; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_mem_w", mem_w, 0);
        @(posedge clk); #1;
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
        check_mem();

        run_copy(30, 60, 6, 6, 3, 0);
        check_mem();

        run_copy(20, 40, 5, 2, 0, 6);
        check_mem();

        run_copy(50, 70, 3, 3, 0, 0);
        check_mem();

        run_copy(80, 82, 5, 5, 0, 0);
        check_mem();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
